can_frame_decoder: RTL and testbench

//  Downstream of the CAN bit unstuffer. Consumes the unstuffed bit stream, one bit per bit_valid strobe,
//  and parses base and extended data/remote frames into ID/DLC/data fields.

---
 rtl/can_frame_decoder.sv | 279 +++++++++++++++++++++++++++
 tb/tb_can_frame_decoder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_frame_decoder.sv
// rtl/can_frame_decoder.sv - CAN base/extended frame parser behind the bit unstuffer
//
// Purpose:
//   Consumes the unstuffed CAN bit stream (one bit per bit_valid strobe) and
//   parses base and extended data/remote frames into ID, DLC and data fields.
//   Checks the CRC-15 and the fixed-form delimiter/EOF bits, and drives the
//   unstuffer enable, which is active from SOF through the last CRC bit.
//
// Ports:
//   clkin        in   1   system clock, all logic on posedge
//   rst_n        in   1   asynchronous active-low reset
//   bit_in       in   1   unstuffed bit (1 = recessive), valid with bit_valid
//   bit_valid    in   1   one-cycle strobe per unstuffed bit
//   stuff_err    in   1   unstuffer error flag, sampled with bit_valid
//   unstuff_en   out  1   unstuffer enable, SOF .. last CRC bit
//   busy         out  1   decoder is not sitting in IDLE
//   frame_valid  out  1   one-cycle pulse: good frame received
//   frame_id     out  29  identifier (base frames in [10:0])
//   frame_ide    out  1   extended frame flag
//   frame_rtr    out  1   remote frame flag
//   frame_dlc    out  4   DLC as received
//   frame_data   out  64  byte0 in [63:56], first received bit is MSB
//   crc_err      out  1   one-cycle pulse: CRC mismatch
//   form_err     out  1   one-cycle pulse: fixed-form bit or stuff error

module can_frame_decoder #(
  parameter int          IDLE_BITS = 11,
  parameter logic [14:0] CRC_POLY  = 15'h4599
) (
  input  logic        clkin,
  input  logic        rst_n,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        stuff_err,
  output logic        unstuff_en,
  output logic        busy,
  output logic        frame_valid,
  output logic [28:0] frame_id,
  output logic        frame_ide,
  output logic        frame_rtr,
  output logic [3:0]  frame_dlc,
  output logic [63:0] frame_data,
  output logic        crc_err,
  output logic        form_err
);

  typedef enum logic [3:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_ID_A,
    S_SRR_RTR,
    S_IDE,
    S_ID_B,
    S_RTR,
    S_R1,
    S_R0,
    S_DLC,
    S_DATA,
    S_CRC,
    S_CRC_DEL,
    S_ACK,
    S_ACK_DEL,
    S_EOF
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [6:0]  bit_cnt;
  logic [14:0] crc_reg;
  logic [13:0] crc_rx;
  logic        crc_bad;
  logic [28:0] id_sr;
  logic        ide_r;
  logic        rtr_r;
  logic [3:0]  dlc_r;
  logic [63:0] data_sr;

  logic [6:0]  field_len;
  logic        field_done;
  logic [3:0]  dlc_full;
  logic [14:0] crc_rx_full;
  logic        ev_valid;
  logic        ev_crc;
  logic        ev_form;

  // Number of DATA bits implied by RTR and DLC; DLC values above 8 mean 8 bytes.
  function automatic logic [6:0] data_bits(input logic rtr, input logic [3:0] dlc);
    if (rtr) begin
      return 7'd0;
    end else if (dlc >= 4'd8) begin
      return 7'd64;
    end else begin
      return {1'b0, dlc[2:0], 3'b000};
    end
  endfunction

  // One step of the CAN CRC-15 shift register.
  function automatic logic [14:0] crc_step(input logic [14:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[14];
    return {crc[13:0], 1'b0} ^ (fb ? CRC_POLY : 15'd0);
  endfunction

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_WAIT_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    ev_valid    = 1'b0;
    ev_crc      = 1'b0;
    ev_form     = 1'b0;
    dlc_full    = {dlc_r[2:0], bit_in};
    crc_rx_full = {crc_rx, bit_in};

    case (state)
      S_WAIT_IDLE: field_len = 7'(IDLE_BITS);
      S_ID_A:      field_len = 7'd11;
      S_ID_B:      field_len = 7'd18;
      S_DLC:       field_len = 7'd4;
      S_DATA:      field_len = data_bits(rtr_r, dlc_r);
      S_CRC:       field_len = 7'd15;
      S_EOF:       field_len = 7'd7;
      default:     field_len = 7'd1;
    endcase
    field_done = (bit_cnt == field_len - 7'd1);

    if (bit_valid) begin
      if (stuff_err && unstuff_en) begin
        ev_form    = 1'b1;
        state_next = S_WAIT_IDLE;
      end else begin
        case (state)
          S_WAIT_IDLE: if (bit_in && field_done) state_next = S_IDLE;
          S_IDLE:      if (!bit_in) state_next = S_ID_A;
          S_ID_A:      if (field_done) state_next = S_SRR_RTR;
          S_SRR_RTR:   state_next = S_IDE;
          S_IDE:       state_next = bit_in ? S_ID_B : S_R0;
          S_ID_B:      if (field_done) state_next = S_RTR;
          S_RTR:       state_next = S_R1;
          S_R1:        state_next = S_R0;
          S_R0:        state_next = S_DLC;
          S_DLC: begin
            if (field_done) begin
              state_next = (data_bits(rtr_r, dlc_full) == 7'd0) ? S_CRC : S_DATA;
            end
          end
          S_DATA:      if (field_done) state_next = S_CRC;
          S_CRC:       if (field_done) state_next = S_CRC_DEL;
          S_CRC_DEL: begin
            // A CRC mismatch takes precedence over a bad delimiter so that
            // exactly one error event is reported for the frame.
            if (crc_bad) begin
              ev_crc     = 1'b1;
              state_next = S_WAIT_IDLE;
            end else if (!bit_in) begin
              ev_form    = 1'b1;
              state_next = S_WAIT_IDLE;
            end else begin
              state_next = S_ACK;
            end
          end
          S_ACK:       state_next = S_ACK_DEL;
          S_ACK_DEL: begin
            if (!bit_in) begin
              ev_form    = 1'b1;
              state_next = S_WAIT_IDLE;
            end else begin
              state_next = S_EOF;
            end
          end
          S_EOF: begin
            if (!bit_in) begin
              ev_form    = 1'b1;
              state_next = S_WAIT_IDLE;
            end else if (field_done) begin
              ev_valid   = 1'b1;
              state_next = S_IDLE;
            end
          end
          default:     state_next = S_WAIT_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= 7'd0;
      crc_reg     <= 15'd0;
      crc_rx      <= 14'd0;
      crc_bad     <= 1'b0;
      id_sr       <= 29'd0;
      ide_r       <= 1'b0;
      rtr_r       <= 1'b0;
      dlc_r       <= 4'd0;
      data_sr     <= 64'd0;
      unstuff_en  <= 1'b0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      crc_err     <= 1'b0;
      form_err    <= 1'b0;
      frame_id    <= 29'd0;
      frame_ide   <= 1'b0;
      frame_rtr   <= 1'b0;
      frame_dlc   <= 4'd0;
      frame_data  <= 64'd0;
    end else begin
      frame_valid <= ev_valid;
      crc_err     <= ev_crc;
      form_err    <= ev_form;
      // Registered copy of (state != IDLE), aligned with the state register.
      busy        <= (state_next != S_IDLE);

      if (bit_valid) begin
        // WAIT_IDLE counts consecutive recessive bits; every other state
        // counts bits within the current field.
        if (state == S_WAIT_IDLE && state_next == S_WAIT_IDLE) begin
          bit_cnt <= bit_in ? bit_cnt + 7'd1 : 7'd0;
        end else if (state_next != state || state == S_IDLE) begin
          bit_cnt <= 7'd0;
        end else begin
          bit_cnt <= bit_cnt + 7'd1;
        end

        if (ev_form || ev_crc) begin
          unstuff_en <= 1'b0;
        end else if (state == S_IDLE && !bit_in) begin
          unstuff_en <= 1'b1;
        end else if (state == S_CRC && field_done) begin
          unstuff_en <= 1'b0;
        end

        if (state inside {S_ID_A, S_SRR_RTR, S_IDE, S_ID_B, S_RTR, S_R1, S_R0, S_DLC, S_DATA}) begin
          crc_reg <= crc_step(crc_reg, bit_in);
        end

        case (state)
          S_IDLE: begin
            if (!bit_in) begin
              crc_reg <= crc_step(15'd0, bit_in);
              crc_rx  <= 14'd0;
              crc_bad <= 1'b0;
              id_sr   <= 29'd0;
              ide_r   <= 1'b0;
              rtr_r   <= 1'b0;
              dlc_r   <= 4'd0;
              data_sr <= 64'd0;
            end
          end
          S_ID_A, S_ID_B: id_sr <= {id_sr[27:0], bit_in};
          S_SRR_RTR, S_RTR: rtr_r <= bit_in;
          S_IDE:  ide_r <= bit_in;
          S_DLC:  dlc_r <= dlc_full;
          S_DATA: data_sr[6'd63 - bit_cnt[5:0]] <= bit_in;
          S_CRC: begin
            crc_rx <= crc_rx_full[13:0];
            if (field_done) crc_bad <= (crc_rx_full != crc_reg);
          end
          default: ;
        endcase

        if (ev_valid) begin
          frame_id   <= id_sr;
          frame_ide  <= ide_r;
          frame_rtr  <= rtr_r;
          frame_dlc  <= dlc_r;
          frame_data <= data_sr;
        end
      end
    end
  end

endmodule

// File: tb/tb_can_frame_decoder.sv
// tb/tb_can_frame_decoder.sv - self-checking bench for can_frame_decoder

module tb_can_frame_decoder;

  logic        clkin = 1'b0;
  logic        rst_n;
  logic        bit_in;
  logic        bit_valid;
  logic        stuff_err;
  logic        unstuff_en;
  logic        busy;
  logic        frame_valid;
  logic [28:0] frame_id;
  logic        frame_ide;
  logic        frame_rtr;
  logic [3:0]  frame_dlc;
  logic [63:0] frame_data;
  logic        crc_err;
  logic        form_err;

  can_frame_decoder dut (
    .clkin       (clkin),
    .rst_n       (rst_n),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .stuff_err   (stuff_err),
    .unstuff_en  (unstuff_en),
    .busy        (busy),
    .frame_valid (frame_valid),
    .frame_id    (frame_id),
    .frame_ide   (frame_ide),
    .frame_rtr   (frame_rtr),
    .frame_dlc   (frame_dlc),
    .frame_data  (frame_data),
    .crc_err     (crc_err),
    .form_err    (form_err)
  );

  always #5 clkin = ~clkin;

  int checks   = 0;
  int failures = 0;

  int n_valid = 0;
  int n_crc   = 0;
  int n_form  = 0;

  always @(negedge clkin) begin
    if (frame_valid) n_valid++;
    if (crc_err)     n_crc++;
    if (form_err)    n_form++;
  end

  bit          fq[$];
  int          data_pos;
  int          crc_pos;
  int          eof_pos;
  logic [28:0] e_id;
  logic        e_ide;
  logic        e_rtr;
  logic [3:0]  e_dlc;
  logic [63:0] e_data;
  logic        ue_sof;
  logic        ue_crc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Builds the complete bit sequence of a frame; CRC is the remainder of the
  // SOF..DATA polynomial times x^15 divided by x^15 + 0x4599.
  task automatic build(input logic [28:0] id, input bit ide, input bit rtr,
                       input logic [3:0] dlc, input logic [63:0] data, input bit ack);
    bit          r[$];
    int          nbytes;
    int          n;
    logic [15:0] g;
    logic [63:0] ones;
    g    = 16'hC599;
    ones = 64'hFFFF_FFFF_FFFF_FFFF;
    fq.delete();
    fq.push_back(1'b0);
    if (!ide) begin
      for (int i = 10; i >= 0; i--) fq.push_back(id[i]);
      fq.push_back(rtr);
      fq.push_back(1'b0);
      fq.push_back(1'($urandom_range(0, 1)));
    end else begin
      for (int i = 28; i >= 18; i--) fq.push_back(id[i]);
      fq.push_back(1'b1);
      fq.push_back(1'b1);
      for (int i = 17; i >= 0; i--) fq.push_back(id[i]);
      fq.push_back(rtr);
      fq.push_back(1'($urandom_range(0, 1)));
      fq.push_back(1'($urandom_range(0, 1)));
    end
    for (int i = 3; i >= 0; i--) fq.push_back(dlc[i]);
    data_pos = fq.size();
    nbytes = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < nbytes * 8; i++) fq.push_back(data[63 - i]);
    n = fq.size();
    r = fq;
    for (int i = 0; i < 15; i++) r.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      if (r[i]) begin
        for (int j = 0; j < 16; j++) r[i + j] = r[i + j] ^ g[15 - j];
      end
    end
    crc_pos = fq.size();
    for (int k = 0; k < 15; k++) fq.push_back(r[n + k]);
    fq.push_back(1'b1);
    fq.push_back(ack);
    fq.push_back(1'b1);
    eof_pos = fq.size();
    for (int k = 0; k < 7; k++) fq.push_back(1'b1);
    e_id   = ide ? id : {18'd0, id[10:0]};
    e_ide  = ide;
    e_rtr  = rtr;
    e_dlc  = dlc;
    e_data = data & ~(ones >> (nbytes * 8));
  endtask

  task automatic send_bit(input bit b, input bit serr);
    int gap;
    @(negedge clkin);
    bit_in    = b;
    bit_valid = 1'b1;
    stuff_err = serr;
    @(negedge clkin);
    bit_valid = 1'b0;
    stuff_err = 1'($urandom_range(0, 1));
    bit_in    = 1'($urandom_range(0, 1));
    gap = $urandom_range(0, 2);
    repeat (gap) @(negedge clkin);
    stuff_err = 1'b0;
  endtask

  // Sends fq[0..stop] (whole frame when stop < 0), optionally flipping one
  // bit and flagging a stuff error on one bit.
  task automatic send_frame(input int stop, input int flip_idx, input int serr_idx);
    int last;
    bit b;
    last = (stop < 0) ? fq.size() - 1 : stop;
    for (int i = 0; i <= last; i++) begin
      b = fq[i];
      if (i == flip_idx) b = ~b;
      send_bit(b, i == serr_idx);
      if (i == 0) ue_sof = unstuff_en;
      if (i == crc_pos + 14) ue_crc = unstuff_en;
    end
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, 1'b0);
  endtask

  task automatic settle();
    repeat (2) @(negedge clkin);
  endtask

  task automatic chk_fields(input string tag);
    chk({tag, "_id"},   64'(frame_id),  64'(e_id));
    chk({tag, "_ide"},  64'(frame_ide), 64'(e_ide));
    chk({tag, "_rtr"},  64'(frame_rtr), 64'(e_rtr));
    chk({tag, "_dlc"},  64'(frame_dlc), 64'(e_dlc));
    chk({tag, "_data"}, frame_data,     e_data);
  endtask

  initial begin
    int          v0;
    int          c0;
    int          f0;
    logic [28:0] p_id;
    logic [3:0]  p_dlc;
    logic [63:0] p_data;
    logic [28:0] rid;
    bit          ride;
    bit          rrtr;
    logic [3:0]  rdlc;
    logic [63:0] rdata;

    rst_n     = 1'b0;
    bit_in    = 1'b1;
    bit_valid = 1'b0;
    stuff_err = 1'b0;
    repeat (3) @(negedge clkin);
    chk("rst_busy",  64'(busy),        64'd0);
    chk("rst_ue",    64'(unstuff_en),  64'd0);
    chk("rst_valid", 64'(frame_valid), 64'd0);
    chk("rst_errs",  64'({crc_err, form_err}), 64'd0);
    chk("rst_id",    64'(frame_id),    64'd0);
    chk("rst_data",  frame_data,       64'd0);
    rst_n = 1'b1;
    send_idle(11);
    chk("idle_busy", 64'(busy), 64'd0);

    // Base data frame, ID 0x123, DLC 2
    build(29'h123, 1'b0, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, 1'b0);
    v0 = n_valid; c0 = n_crc; f0 = n_form;
    send_frame(-1, -1, -1);
    settle();
    chk("t1_valid", 64'(n_valid - v0), 64'd1);
    chk("t1_errs",  64'((n_crc - c0) + (n_form - f0)), 64'd0);
    chk("t1_ue_sof", 64'(ue_sof), 64'd1);
    chk("t1_ue_crc", 64'(ue_crc), 64'd0);
    chk("t1_busy",   64'(busy),   64'd0);
    chk_fields("t1");

    // Extended remote frame
    build(29'h1ABCDE01, 1'b1, 1'b1, 4'd4, {$urandom, $urandom}, 1'b1);
    v0 = n_valid; c0 = n_crc; f0 = n_form;
    send_frame(-1, -1, -1);
    settle();
    chk("t2_valid", 64'(n_valid - v0), 64'd1);
    chk("t2_errs",  64'((n_crc - c0) + (n_form - f0)), 64'd0);
    chk_fields("t2");

    // CRC bit flipped
    p_id = e_id; p_dlc = e_dlc; p_data = e_data;
    build(29'h123, 1'b0, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, 1'b0);
    v0 = n_valid; c0 = n_crc; f0 = n_form;
    send_frame(crc_pos + 15, crc_pos + 4, -1);
    settle();
    chk("t3_crc",   64'(n_crc - c0),   64'd1);
    chk("t3_valid", 64'(n_valid - v0), 64'd0);
    chk("t3_form",  64'(n_form - f0),  64'd0);
    chk("t3_hold_id",  64'(frame_id),  64'(p_id));
    chk("t3_hold_dlc", 64'(frame_dlc), 64'(p_dlc));
    send_idle(10);
    chk("t3_busy10", 64'(busy), 64'd1);
    send_idle(1);
    chk("t3_busy11", 64'(busy), 64'd0);
    v0 = n_valid;
    send_frame(-1, -1, -1);
    settle();
    chk("t3_next_valid", 64'(n_valid - v0), 64'd1);
    chk_fields("t3_next");

    // Stuff error during DATA
    p_id = e_id; p_dlc = e_dlc; p_data = e_data;
    v0 = n_valid; c0 = n_crc; f0 = n_form;
    send_frame(data_pos + 5, -1, data_pos + 5);
    settle();
    chk("t4_form",  64'(n_form - f0),  64'd1);
    chk("t4_ue",    64'(unstuff_en),   64'd0);
    chk("t4_other", 64'((n_valid - v0) + (n_crc - c0)), 64'd0);
    chk("t4_hold_id",   64'(frame_id), 64'(p_id));
    chk("t4_hold_data", frame_data,    p_data);
    send_idle(11);

    // DLC 15 consumes 64 data bits
    build(29'h123, 1'b0, 1'b0, 4'd15, {16'hABCD, 16'($urandom), $urandom}, 1'b0);
    v0 = n_valid; c0 = n_crc; f0 = n_form;
    send_frame(-1, -1, -1);
    settle();
    chk("t5_valid", 64'(n_valid - v0), 64'd1);
    chk("t5_errs",  64'((n_crc - c0) + (n_form - f0)), 64'd0);
    chk_fields("t5");

    // EOF bit 3 dominant
    v0 = n_valid; f0 = n_form;
    send_frame(eof_pos + 2, eof_pos + 2, -1);
    settle();
    chk("t5_eof_form",  64'(n_form - f0),  64'd1);
    chk("t5_eof_valid", 64'(n_valid - v0), 64'd0);
    send_idle(11);

    // Reset mid-DATA
    build(29'h123, 1'b0, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, 1'b0);
    send_frame(data_pos + 4, -1, -1);
    chk("t6_ue_pre", 64'(unstuff_en), 64'd1);
    @(negedge clkin);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 64'(busy),       64'd0);
    chk("t6_ue",   64'(unstuff_en), 64'd0);
    chk("t6_id",   64'(frame_id),   64'd0);
    chk("t6_dlc",  64'(frame_dlc),  64'd0);
    chk("t6_data", frame_data,      64'd0);
    @(negedge clkin);
    rst_n = 1'b1;
    send_idle(5);
    send_bit(1'b0, 1'b0);
    chk("t6_nosof_ue", 64'(unstuff_en), 64'd0);
    send_idle(10);
    chk("t6_busy10", 64'(busy), 64'd1);
    send_idle(1);
    chk("t6_busy11", 64'(busy), 64'd0);
    v0 = n_valid;
    send_frame(-1, -1, -1);
    settle();
    chk("t6_valid", 64'(n_valid - v0), 64'd1);
    chk_fields("t6");

    // Randomized good frames
    for (int k = 0; k < 10; k++) begin
      ride  = 1'($urandom_range(0, 1));
      rrtr  = 1'($urandom_range(0, 1));
      rdlc  = 4'($urandom_range(0, 15));
      rid   = ride ? 29'($urandom) : {18'd0, 11'($urandom)};
      rdata = {$urandom, $urandom};
      build(rid, ride, rrtr, rdlc, rdata, 1'($urandom_range(0, 1)));
      v0 = n_valid; c0 = n_crc; f0 = n_form;
      send_frame(-1, -1, -1);
      settle();
      chk("rnd_valid", 64'(n_valid - v0), 64'd1);
      chk("rnd_errs",  64'((n_crc - c0) + (n_form - f0)), 64'd0);
      chk_fields("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
